prob_table_rx: RTL
==================

// Module: prob_table_rx
// PURPOSE
//  Receiving end of the probability-table write protocol used to program the BER system.
//  Accepts (probability_idx, probability_in) beats and stores them in a DEPTH x DATA_W table.
//  Tracks which entries have been loaded and commits the table once it is complete.
//  Serves 1-cycle-latency lookups to the noise-injection cores.
// PARAMETERS
//  DEPTH     64             number of table entries
//  DATA_W    64             entry width (probability threshold)
//  ADDR_W    6              lookup address width, clog2(DEPTH)
//  IDX_W     32             width of probability_idx
//  IDLE_IDX  32'hFFFFFFFF   idx value meaning "no write this cycle"
// PORTS
//  clk              in   1        system clock
//  rst              in   1        synchronous reset, active-high
//  probability_idx  in   IDX_W    write index; IDLE_IDX = idle
//  probability_in   in   DATA_W   write data, sampled with probability_idx
//  rd_en            in   1        lookup request
//  rd_addr          in   ADDR_W   lookup index
//  rd_data          out  DATA_W   lookup result
//  rd_valid         out  1        rd_data valid (1 cycle after rd_en)
//  table_ready      out  1        table complete and committed
//  load_count       out  ADDR_W+1 number of distinct entries loaded since last clear
//  load_error       out  1        sticky: out-of-range idx received
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=EMPTY; loaded bitmap=0; rd_data=0; rd_valid=0;
//    table_ready=0; load_count=0; load_error=0. Table RAM contents are not cleared.
//  - Beat classification each cycle: idx==IDLE_IDX -> idle; idx<DEPTH -> valid write;
//    any other value -> no write, load_error<=1 (sticky until rst).
//  - A valid write stores probability_in at entry idx[ADDR_W-1:0] and sets bitmap[idx].
//  - load_count = popcount(bitmap), registered, so it updates the cycle after the write.
//    Rewriting an already-loaded entry overwrites the data and does not increment load_count.
//  - FSM:
//    EMPTY   -> LOADING on a valid write.
//    LOADING -> READY when bitmap is all-ones AND the current beat is idle.
//               The commit cycle must be idle. If the final write arrives and idx is still
//               non-idle next cycle, the FSM stays in LOADING.
//    READY   -> LOADING on any valid write. The bitmap is cleared and then the written bit
//               is set, so load_count becomes 1. table_ready drops the next cycle.
//  - table_ready is 1 iff state==READY (registered).
//  - load_error does not block commit, but the verification bench flags it.
//  - Lookup:
//    rd_en=1 at cycle N -> rd_data=table[rd_addr] and rd_valid=1 at N+1.
//    rd_en=0 -> rd_valid=0 and rd_data holds its last value.
//    Lookups are served in every state. Consumers gate on table_ready.
//  - Simultaneous write and read to the same entry: read-first. rd_data returns the old
//    value; the new value is visible from the next read.
//  - rst asserted mid-load: everything returns to EMPTY. A full reload (all DEPTH entries)
//    is required before table_ready reasserts.
// TESTING
//  1. Write idx 0..63 with data=idx*0x0101, then one idle cycle
//     -> load_count 1..64, table_ready=1 on the cycle after the idle beat.
//  2. Write idx 0..63 back-to-back with idx held at 63 for 2 extra cycles, then idle
//     -> table_ready stays 0 until the first idle cycle.
//  3. In READY, write idx 5 = 64'hDEAD
//     -> table_ready=0 next cycle, load_count=1; reading addr 5 returns 64'hDEAD.
//  4. Write idx 10 twice (0xA, then 0xB)
//     -> load_count increments once; a read of addr 10 returns 0xB.
//  5. idx=64, then idx=32'h8000_0000
//     -> load_error=1 and stays 1; no table entry changes; load_count unchanged.
//  6. Same-cycle write and read of addr 7 (old 0x1, new 0x2)
//     -> rd_data=0x1; the next read returns 0x2.
//     Also: rst mid-load at count 30 -> load_count=0, state EMPTY.

Source files
------------

// File: rtl/prob_table_if.sv
// Probability-table link: write beats from the programming side and
// lookup requests/results for the noise-injection cores.
interface prob_table_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int IDX_W  = 32
);
  logic [IDX_W-1:0]  probability_idx;
  logic [DATA_W-1:0] probability_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              table_ready;
  logic [ADDR_W:0]   load_count;
  logic              load_error;

  // Programming/lookup side
  modport master (
    output probability_idx, probability_in, rd_en, rd_addr,
    input  rd_data, rd_valid, table_ready, load_count, load_error
  );

  // Table side
  modport slave (
    input  probability_idx, probability_in, rd_en, rd_addr,
    output rd_data, rd_valid, table_ready, load_count, load_error
  );
endinterface

// File: rtl/prob_table_rx.sv
// Receiver for the probability-table write protocol. Stores beats in a
// DEPTH x DATA_W table, tracks which entries are loaded, commits the table
// on the first idle beat after it becomes complete, and serves 1-cycle
// lookups in every state.
module prob_table_rx #(
  parameter int              DEPTH    = 64,
  parameter int              DATA_W   = 64,
  parameter int              ADDR_W   = 6,
  parameter int              IDX_W    = 32,
  parameter logic [IDX_W-1:0] IDLE_IDX = {IDX_W{1'b1}}
) (
  input logic         clk,
  input logic         rst,
  prob_table_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DEPTH-1:0]  r_bitmap;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_error;
  state_t            r_state;

  state_t            w_state_next;
  logic              w_idle;
  logic              w_wr;
  logic              w_bad;
  logic              w_clear;
  logic              w_full;
  logic [ADDR_W-1:0] w_addr;
  logic [DEPTH-1:0]  w_bitmap_next;
  logic [ADDR_W:0]   w_count_next;

  // Beat classification: idle marker, in-range write, or out-of-range error.
  assign w_idle  = (bus.probability_idx == IDLE_IDX);
  assign w_wr    = !w_idle && (bus.probability_idx < DEPTH_IDX);
  assign w_bad   = !w_idle && !w_wr;
  assign w_addr  = bus.probability_idx[ADDR_W-1:0];
  assign w_full  = &r_bitmap;
  // A write arriving after commit starts a fresh load from an empty bitmap.
  assign w_clear = w_wr && (r_state == ST_READY);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bitmap
      assign w_bitmap_next[gi] = (w_wr && (w_addr == ADDR_W'(gi))) ? 1'b1 :
                                 (w_clear ? 1'b0 : r_bitmap[gi]);
    end
  endgenerate

  // Popcount of the next bitmap so load_count lands together with the bitmap.
  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + (ADDR_W+1)'(w_bitmap_next[i]);
    end
  end

  // Table storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_addr] <= bus.probability_in;
    end
  end

  // Registered lookup, read-first against a same-cycle write; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= r_mem[bus.rd_addr];
      end
    end
  end

  // Load tracking: bitmap, its population count and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitmap     <= '0;
      r_load_count <= '0;
      r_load_error <= 1'b0;
    end else begin
      r_bitmap     <= w_bitmap_next;
      r_load_count <= w_count_next;
      if (w_bad) begin
        r_load_error <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: commit needs a complete bitmap and an idle beat.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY:   if (w_wr) w_state_next = ST_LOADING;
      ST_LOADING: if (w_full && w_idle) w_state_next = ST_READY;
      ST_READY:   if (w_wr) w_state_next = ST_LOADING;
      default:    w_state_next = ST_EMPTY;
    endcase
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.table_ready = (r_state == ST_READY);
  assign bus.load_count  = r_load_count;
  assign bus.load_error  = r_load_error;

endmodule
